// File: rtl/fifo_sync_param_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_param_pkg
// Shared constants and elaboration-time helpers for the parametrised
// single-clock FIFO. It has no ports.
//   DEF_DATA_W / DEF_DEPTH : default geometry used by the top and the interface
//   clog2()                : ceiling log2, sizes pointers and the level counter
//   is_pow2()              : parameter legality check for DEPTH
// -----------------------------------------------------------------------------
package fifo_sync_param_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_DEPTH  = 16;

    // Ceiling log2. Returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// -----------------------------------------------------------------------------
// fifo_sync_param_if
// Producer/consumer bundle of the FIFO. The FIFO connects through the slave
// modport. The producer/consumer side, or a testbench, uses master.
//   wren, wdata       : write request and its data
//   rden              : read request (in FWFT mode it pops the head word)
//   rdata             : read data
//   full, empty       : level == DEPTH / level == 0
//   almost_full/empty : level >= AF_LEVEL / level <= AE_LEVEL
//   level             : occupancy 0..DEPTH
//   overflow/underflow: sticky error bits
//   clr_err           : clears the sticky error bits
// The interface must be built with the same DATA_W/DEPTH as the FIFO.
// -----------------------------------------------------------------------------
interface fifo_sync_param_if #(
    parameter int DATA_W = fifo_sync_param_pkg::DEF_DATA_W,
    parameter int DEPTH  = fifo_sync_param_pkg::DEF_DEPTH
);
    import fifo_sync_param_pkg::*;

    localparam int AW = clog2(DEPTH);

    logic              wren;
    logic [DATA_W-1:0] wdata;
    logic              rden;
    logic [DATA_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       level;
    logic              overflow;
    logic              underflow;
    logic              clr_err;

    modport master (
        output wren, wdata, rden, clr_err,
        input  rdata, full, empty, almost_full, almost_empty, level,
               overflow, underflow
    );

    modport slave (
        input  wren, wdata, rden, clr_err,
        output rdata, full, empty, almost_full, almost_empty, level,
               overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_param_dpram.sv
// -----------------------------------------------------------------------------
// fifo_sync_param_dpram
// Storage array of DEPTH x DATA_W words. It has one write port and one read
// port, both on the same clock.
//   clk, reset : clock; reset clears only the registered read output
//   i_we       : write enable, stores i_wdata at i_waddr
//   i_re       : read enable (registered-read mode only)
//   i_raddr    : read address
//   o_rdata    : read data. When SYNC_READ=1 it is registered and updates
//                only on i_re. When SYNC_READ=0 it is a combinational look-up.
// -----------------------------------------------------------------------------
module fifo_sync_param_dpram
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SYNC_READ = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_we,
    input  logic [clog2(DEPTH)-1:0]  i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [clog2(DEPTH)-1:0]  i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array is deliberately left out of reset so that it maps onto
    // plain RAM; the FIFO pointers alone define which entries are valid.
    // NOTE: clocked state is always assigned with <= so every flop samples
    // the values that existed before the edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    if (SYNC_READ != 0) begin : g_sync_read
        logic [DATA_W-1:0] r_rdata;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata <= '0;
            end else if (i_re) begin
                r_rdata <= r_mem[i_raddr];
            end
        end

        assign o_rdata = r_rdata;
    end else begin : g_async_read
        // In this mode the read is purely combinational. Reset and read
        // enable have no function here.
        logic w_unused_async;
        assign w_unused_async = reset | i_re;

        assign o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
// Single-clock parametrised FIFO. It provides an occupancy count,
// programmable almost-full/almost-empty flags, sticky overflow/underflow
// errors and an optional first-word-fall-through read mode.
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-high, overrides every other input
//   bus   : fifo_sync_param_if.slave (write/read requests, data, status)
// Parameters: DATA_W, DEPTH (power of 2, >= 2), AF_LEVEL, AE_LEVEL,
//             FWFT (0 = registered read, 1 = first-word-fall-through).
// -----------------------------------------------------------------------------
module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             reset,
    fifo_sync_param_if.slave bus
);

    localparam int AW = clog2(DEPTH);

    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];
    localparam logic [AW:0] LVL_AF   = AF_LEVEL[AW:0];
    localparam logic [AW:0] LVL_AE   = AE_LEVEL[AW:0];

    // ---------------- parameter legality ----------------
    if (DATA_W < 1) begin : g_chk_data_w
        $error("fifo_sync_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_chk_depth
        $error("fifo_sync_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_chk_af
        $error("fifo_sync_param: AF_LEVEL must lie in 0..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_chk_ae
        $error("fifo_sync_param: AE_LEVEL must lie in 0..DEPTH");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
        $error("fifo_sync_param: FWFT must be 0 or 1");
    end

    // ---------------- state ----------------
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);

    // Acceptance looks only at the registered level. A read in the same
    // cycle does not make room for a write, and a write does not feed a read.
    assign w_wr_acc = bus.wren & ~w_full;
    assign w_rd_acc = bus.rden & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Pointers are exactly AW bits wide, so they wrap mod DEPTH
            // without any compare logic.
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            // A new error outranks a clear in the same cycle.
            r_overflow  <= (bus.wren & w_full)  | (r_overflow  & ~bus.clr_err);
            r_underflow <= (bus.rden & w_empty) | (r_underflow & ~bus.clr_err);
        end
    end

    // ---------------- storage ----------------
    fifo_sync_param_dpram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .SYNC_READ ((FWFT == 0) ? 1 : 0)
    ) u_dpram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wdata),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // ---------------- read data path ----------------
    if (FWFT != 0) begin : g_fwft
        // The head word is shown straight from the array. While the FIFO is
        // empty, the output holds the last head it showed. This keeps rdata
        // stable and leaves it at 0 after reset.
        logic [DATA_W-1:0] r_hold;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_hold <= '0;
            end else if (!w_empty) begin
                r_hold <= w_mem_rdata;
            end
        end

        assign bus.rdata = w_empty ? r_hold : w_mem_rdata;
    end else begin : g_registered
        assign bus.rdata = w_mem_rdata;
    end

    // ---------------- status decode ----------------
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_level >= LVL_AF);
    assign bus.almost_empty = (r_level <= LVL_AE);
    assign bus.level        = r_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_param
// Runs a registered-read FIFO (dut0) and a first-word-fall-through FIFO
// (dut1) side by side on the same stimulus. Both are compared against a
// queue-based reference model. The bench applies a short hand-written
// vector table, the directed corner sequences, and then a randomized run.
// -----------------------------------------------------------------------------
module tb_fifo_sync_param;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF     = 14;
    localparam int AE     = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
    fifo_sync_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

    fifo_sync_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    fifo_sync_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_rd0;   // registered-read output
    logic [DATA_W-1:0] m_rd1;   // fall-through output (head, or last head)
    bit                m_ovf;
    bit                m_unf;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit wr, input logic [DATA_W-1:0] wd,
                                input bit rd, input bit clr);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_rd0 = '0;
            m_rd1 = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr && was_full)      m_ovf = 1'b1;
            else if (clr)            m_ovf = 1'b0;
            if (rd && was_empty)     m_unf = 1'b1;
            else if (clr)            m_unf = 1'b0;
            if (rd && !was_empty)    m_rd0 = q.pop_front();
            if (wr && !was_full)     q.push_back(wd);
            if (q.size() > 0)        m_rd1 = q[0];
        end
    endtask

    task automatic compare_one(input string tag, input int lvl, input bit full, input bit empty,
                               input bit af, input bit ae, input bit ovf, input bit unf,
                               input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] exp_rd);
        int m_lvl;
        m_lvl = q.size();
        check({tag, "_level"},        lvl,   m_lvl);
        check({tag, "_full"},         full,  m_lvl == DEPTH);
        check({tag, "_empty"},        empty, m_lvl == 0);
        check({tag, "_almost_full"},  af,    m_lvl >= AF);
        check({tag, "_almost_empty"}, ae,    m_lvl <= AE);
        check({tag, "_overflow"},     ovf,   m_ovf);
        check({tag, "_underflow"},    unf,   m_unf);
        check({tag, "_rdata"},        rdata, exp_rd);
    endtask

    // One clock cycle. The task drives the inputs, waits for the edge, then
    // samples just after it and compares both DUTs with the model.
    task automatic step(input bit rst, input bit wr, input logic [DATA_W-1:0] wd,
                        input bit rd, input bit clr);
        reset      = rst;
        bus0.wren  = wr;  bus1.wren  = wr;
        bus0.wdata = wd;  bus1.wdata = wd;
        bus0.rden  = rd;  bus1.rden  = rd;
        bus0.clr_err = clr; bus1.clr_err = clr;
        @(posedge clk);
        #1;
        model_update(rst, wr, wd, rd, clr);
        compare_one("reg",  int'(bus0.level), bus0.full, bus0.empty, bus0.almost_full,
                    bus0.almost_empty, bus0.overflow, bus0.underflow, bus0.rdata, m_rd0);
        compare_one("fwft", int'(bus1.level), bus1.full, bus1.empty, bus1.almost_full,
                    bus1.almost_empty, bus1.overflow, bus1.underflow, bus1.rdata, m_rd1);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit                rst;
        bit                wr;
        logic [DATA_W-1:0] wd;
        bit                rd;
        bit                clr;
        int                lvl;
        logic [DATA_W-1:0] rd0;
        logic [DATA_W-1:0] rd1;
        bit                ovf;
        bit                unf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        //          rst wr  wd    rd  clr  lvl rd0   rd1   ovf unf
        vecs[0] = '{1,  0, 4'h0, 0,  0,   0, 4'h0, 4'h0, 0,  0};
        vecs[1] = '{0,  0, 4'h0, 1,  0,   0, 4'h0, 4'h0, 0,  1};  // read empty
        vecs[2] = '{0,  0, 4'h0, 0,  1,   0, 4'h0, 4'h0, 0,  0};  // clear
        vecs[3] = '{0,  1, 4'h7, 0,  0,   1, 4'h0, 4'h7, 0,  0};
        vecs[4] = '{0,  1, 4'h9, 0,  0,   2, 4'h0, 4'h7, 0,  0};
        vecs[5] = '{0,  0, 4'h0, 1,  0,   1, 4'h7, 4'h9, 0,  0};
        vecs[6] = '{0,  1, 4'h2, 1,  0,   1, 4'h9, 4'h2, 0,  0};  // write + read
        vecs[7] = '{0,  0, 4'h0, 1,  0,   0, 4'h2, 4'h2, 0,  0};  // last word out
        vecs[8] = '{0,  0, 4'h0, 1,  1,   0, 4'h2, 4'h2, 0,  1};  // set beats clear
        vecs[9] = '{0,  0, 4'h0, 0,  1,   0, 4'h2, 4'h2, 0,  0};

        reset = 1'b1;
        bus0.wren = 1'b0; bus0.wdata = '0; bus0.rden = 1'b0; bus0.clr_err = 1'b0;
        bus1.wren = 1'b0; bus1.wdata = '0; bus1.rden = 1'b0; bus1.clr_err = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd, vecs[i].clr);
            check($sformatf("tbl%0d_level", i),  bus0.level,     vecs[i].lvl);
            check($sformatf("tbl%0d_rdata0", i), bus0.rdata,     vecs[i].rd0);
            check($sformatf("tbl%0d_rdata1", i), bus1.rdata,     vecs[i].rd1);
            check($sformatf("tbl%0d_ovf", i),    bus0.overflow,  vecs[i].ovf);
            check($sformatf("tbl%0d_unf", i),    bus0.underflow, vecs[i].unf);
        end

        // ---- 1: fill to full, then drain in order ----
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
            check("t1_almost_full", bus0.almost_full, (i + 1) >= AF);
        end
        check("t1_level_full", bus0.level, DEPTH);
        check("t1_full",       bus0.full,  1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
            check("t1_rdata_order", bus0.rdata, i);
        end
        check("t1_empty", bus0.empty, 1);

        // ---- 2: overflow when full, then clear ----
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        check("t2_overflow", bus0.overflow, 1);
        check("t2_level",    bus0.level,    DEPTH);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("t2_overflow_clr", bus0.overflow, 0);
        // No write-through when full: the read is taken but the write is dropped.
        step(1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
        check("t2_full_wr_rd_level", bus0.level, DEPTH - 1);
        check("t2_full_wr_rd_ovf",   bus0.overflow, 1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t2_drain_last", bus0.rdata, 15);

        // ---- 3: underflow when empty, rdata held ----
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t3_underflow", bus0.underflow, 1);
        check("t3_rdata_hold", bus0.rdata, 15);
        check("t3_level", bus0.level, 0);
        // No bypass when empty: the write lands but the read is rejected.
        step(1'b0, 1'b1, 4'h4, 1'b1, 1'b1);
        check("t3_empty_wr_rd_level", bus0.level, 1);
        check("t3_empty_wr_rd_unf",   bus0.underflow, 1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        check("t3_after_bypass_rdata", bus0.rdata, 4);

        // ---- 4: steady state at level 8 with wrapping pointers ----
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'(i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, 4'(k + 8), 1'b1, 1'b0);
            check("t4_stream_rdata", bus0.rdata, k % 16);
            check("t4_level", bus0.level, 8);
        end
        for (int k = 40; k < 48; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0);
            check("t4_tail_rdata", bus0.rdata, k % 16);
        end

        // ---- 5: fall-through head visible without rden ----
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
        check("t5_fwft_head", bus1.rdata, 5);
        idle();
        check("t5_fwft_head_stable", bus1.rdata, 5);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t5_fwft_empty", bus1.empty, 1);

        // ---- 6: reset mid-stream ----
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'(i + 6), 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hF, 1'b1, 1'b0);
        check("t6_level", bus0.level, 0);
        check("t6_empty", bus0.empty, 1);
        check("t6_ovf",   bus0.overflow, 0);
        step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("t6_rdata", bus0.rdata, 3);

        // ---- randomized run against the model ----
        for (int c = 0; c < 800; c++) begin
            int wp;
            wp = ((c / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 249) == 0,
                 $urandom_range(0, 99) < wp,
                 4'($urandom),
                 $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
